ram_arbiter: RTL and testbench

- Shares the single-port synchronous video/program RAM between three requesters: the VGA renderer (video), the I2S sample fetcher (audio) and the 65C02 core (cpu).
- Sits between the requesters and `generic_ram`. It replaces ad-hoc address muxing and RDY gating.
- Video has fixed top priority. Audio and cpu share the remaining slots round-robin. An optional starvation guard protects the cpu.

---
 rtl/ram_arb_pkg.sv | 13 +
 rtl/rr_pick2.sv | 28 ++
 rtl/ram_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared owner-tag encoding for the video/audio/cpu RAM arbiter
package ram_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_AUD  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin chooser between audio (a) and cpu (b)
module rr_pick2 (
  input  logic clk,
  input  logic reset_n,
  input  logic req_a,
  input  logic req_b,
  input  logic advance,
  output logic gnt_a,
  output logic gnt_b
);

  // last_b = 1 means b was served last, so a is favoured on a tie
  logic last_b;

  always_comb begin
    gnt_a = req_a & (~req_b | last_b);
    gnt_b = req_b & (~req_a | ~last_b);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_b <= 1'b1;
    end else if (advance && (gnt_a || gnt_b)) begin
      last_b <= gnt_b;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter: video fixed priority, audio/cpu round-robin
import ram_arb_pkg::*;

module ram_arbiter #(
  parameter int AW           = 11,
  parameter int DW           = 8,
  parameter int CPU_MAX_WAIT = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  input  logic          aud_req,
  input  logic [AW-1:0] aud_addr,
  output logic          aud_gnt,
  output logic          aud_rvalid,
  output logic [DW-1:0] aud_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int WCW = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(CPU_MAX_WAIT);

  logic           run;
  owner_t         tag;
  owner_t         next_tag;
  logic [WCW-1:0] wait_cnt;
  logic           cpu_done_q;
  logic [DW-1:0]  cpu_rdata_q;

  logic cpu_elig;
  logic starve_force;
  logic force_cpu;
  logic vid_take;
  logic rr_aud;
  logic rr_cpu;

  // An in-flight cpu read (tag == OWN_CPU) must not be re-granted before it completes
  assign cpu_elig     = cpu_req & ~cpu_done_q & (tag != OWN_CPU);
  assign starve_force = (CPU_MAX_WAIT > 0) && (wait_cnt >= WAIT_LIM);
  assign force_cpu    = starve_force & cpu_elig;
  assign vid_take     = vid_req & ~force_cpu;

  rr_pick2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req_a   (aud_req & ~force_cpu),
    .req_b   (cpu_elig),
    .advance (run & ~vid_take),
    .gnt_a   (rr_aud),
    .gnt_b   (rr_cpu)
  );

  assign vid_gnt = run & vid_take;
  assign aud_gnt = run & ~vid_take & rr_aud;
  assign cpu_gnt = run & ~vid_take & rr_cpu;

  always_comb begin
    ram_addr = '0;
    next_tag = OWN_NONE;
    if (vid_gnt) begin
      ram_addr = vid_addr;
      next_tag = OWN_VID;
    end else if (aud_gnt) begin
      ram_addr = aud_addr;
      next_tag = OWN_AUD;
    end else if (cpu_gnt) begin
      ram_addr = cpu_addr;
      next_tag = cpu_we ? OWN_NONE : OWN_CPU;
    end
  end

  assign ram_we    = cpu_gnt & cpu_we;
  assign ram_wdata = cpu_gnt ? cpu_wdata : '0;

  assign vid_rvalid = (tag == OWN_VID);
  assign aud_rvalid = (tag == OWN_AUD);
  assign vid_rdata  = ram_rdata;
  assign aud_rdata  = ram_rdata;
  assign cpu_done   = cpu_done_q;
  assign cpu_rdata  = cpu_rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      tag         <= OWN_NONE;
      wait_cnt    <= '0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      run <= 1'b1;
      tag <= next_tag;

      if (ram_we) begin
        cpu_done_q <= 1'b1;
      end else if (tag == OWN_CPU) begin
        cpu_done_q  <= 1'b1;
        cpu_rdata_q <= ram_rdata;
      end else if (!cpu_req) begin
        cpu_done_q <= 1'b0;
      end

      if (run && cpu_elig && !cpu_gnt) begin
        if (wait_cnt != '1) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench, two arbiters (guard off / guard = 4) against a reference model
module tb_ram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int NONE = 0, V = 1, A = 2, C = 3;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic reset_n;
  logic fill;
  logic vid_req;
  logic [AW-1:0] vid_addr;
  logic aud_req;
  logic [AW-1:0] aud_addr;
  logic [1:0] cpu_req;
  logic [1:0] cpu_we;
  logic [1:0][AW-1:0] cpu_addr;
  logic [1:0][DW-1:0] cpu_wdata;

  logic [1:0] vid_gnt, vid_rvalid, aud_gnt, aud_rvalid, cpu_gnt, cpu_done, ram_we;
  logic [1:0][DW-1:0] vid_rdata, aud_rdata, cpu_rdata, ram_wdata;
  logic [1:0][AW-1:0] ram_addr;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] init_val(int a);
    return (a == 16) ? 8'h5A : 8'((a * 37) + 11);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdq;

    ram_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(4 * g)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .vid_req    (vid_req),
      .vid_addr   (vid_addr),
      .vid_gnt    (vid_gnt[g]),
      .vid_rvalid (vid_rvalid[g]),
      .vid_rdata  (vid_rdata[g]),
      .aud_req    (aud_req),
      .aud_addr   (aud_addr),
      .aud_gnt    (aud_gnt[g]),
      .aud_rvalid (aud_rvalid[g]),
      .aud_rdata  (aud_rdata[g]),
      .cpu_req    (cpu_req[g]),
      .cpu_we     (cpu_we[g]),
      .cpu_addr   (cpu_addr[g]),
      .cpu_wdata  (cpu_wdata[g]),
      .cpu_gnt    (cpu_gnt[g]),
      .cpu_done   (cpu_done[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .ram_addr   (ram_addr[g]),
      .ram_we     (ram_we[g]),
      .ram_wdata  (ram_wdata[g]),
      .ram_rdata  (rdq)
    );

    always @(posedge clk) begin
      if (fill) begin
        for (int i = 0; i < 2**AW; i++) mem[i] <= init_val(i);
      end else if (ram_we[g]) begin
        mem[ram_addr[g]] <= ram_wdata[g];
      end
      rdq <= mem[ram_addr[g]];
    end
  end

  // Reference model: winner per cycle from the priority rules, reads as an in-flight record
  int          m_run [2];
  int          m_last_cpu [2];
  int          m_done [2];
  int          m_wait [2];
  int          m_fl_own [2];
  logic [7:0]  m_fl_data [2];
  logic [7:0]  m_rdata [2];
  logic [7:0]  m_mem [2][2**AW];

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_clear(int k);
    m_run[k] = 0;
    m_last_cpu[k] = 1;
    m_done[k] = 0;
    m_wait[k] = 0;
    m_fl_own[k] = NONE;
    m_fl_data[k] = 8'h00;
    m_rdata[k] = 8'h00;
  endtask

  task automatic sample();
    #1;
    for (int k = 0; k < 2; k++) begin
      int mw;
      int win;
      bit elig;
      bit frc;
      logic [AW-1:0] ea;
      mw = 4 * k;
      if (!reset_n) model_clear(k);
      elig = cpu_req[k] && (m_done[k] == 0) && (m_fl_own[k] != C);
      frc  = (mw > 0) && (m_wait[k] >= mw) && elig;
      if (m_run[k] == 0)          win = NONE;
      else if (frc)               win = C;
      else if (vid_req)           win = V;
      else if (aud_req && elig)   win = (m_last_cpu[k] != 0) ? A : C;
      else if (aud_req)           win = A;
      else if (elig)              win = C;
      else                        win = NONE;
      ea = (win == V) ? vid_addr : (win == A) ? aud_addr : (win == C) ? cpu_addr[k] : '0;

      check("gnt", k, {vid_gnt[k], aud_gnt[k], cpu_gnt[k]}, {win == V, win == A, win == C});
      check("onehot", k, $countones({vid_gnt[k], aud_gnt[k], cpu_gnt[k]}) <= 1, 1);
      check("ram_addr", k, ram_addr[k], ea);
      check("ram_we", k, ram_we[k], (win == C) && cpu_we[k]);
      check("ram_wdata", k, ram_wdata[k], (win == C) ? cpu_wdata[k] : 8'h00);
      check("rvalid", k, {vid_rvalid[k], aud_rvalid[k]}, {m_fl_own[k] == V, m_fl_own[k] == A});
      if (m_fl_own[k] == V) check("vid_rdata", k, vid_rdata[k], m_fl_data[k]);
      if (m_fl_own[k] == A) check("aud_rdata", k, aud_rdata[k], m_fl_data[k]);
      check("cpu_done", k, cpu_done[k], m_done[k]);
      check("cpu_rdata", k, cpu_rdata[k], m_rdata[k]);

      if (reset_n) begin
        if (win == C && cpu_we[k]) begin
          m_mem[k][cpu_addr[k]] = cpu_wdata[k];
          m_done[k] = 1;
        end else if (m_fl_own[k] == C) begin
          m_rdata[k] = m_fl_data[k];
          m_done[k] = 1;
        end else if (!cpu_req[k]) begin
          m_done[k] = 0;
        end
        if (win == V || win == A || (win == C && !cpu_we[k])) begin
          m_fl_own[k]  = win;
          m_fl_data[k] = m_mem[k][ea];
        end else begin
          m_fl_own[k] = NONE;
        end
        if (win == A || win == C) m_last_cpu[k] = (win == C);
        if (m_run[k] != 0 && elig && win != C) m_wait[k] = (m_wait[k] < 1000) ? m_wait[k] + 1 : 1000;
        else m_wait[k] = 0;
        m_run[k] = 1;
      end
    end
  endtask

  // cpu requester: drops req once done, starts a new access with probability pct
  task automatic cpu_drive(int k, int pct);
    if (cpu_req[k]) begin
      if (m_done[k] != 0) cpu_req[k] = 1'b0;
    end else if (m_done[k] == 0 && $urandom_range(0, 99) < pct) begin
      cpu_req[k]   = 1'b1;
      cpu_we[k]    = 1'($urandom_range(0, 1));
      cpu_addr[k]  = AW'($urandom);
      cpu_wdata[k] = DW'($urandom);
    end
  endtask

  task automatic idle(int n);
    vid_req = 1'b0;
    aud_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) cpu_drive(k, 0);
      sample();
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; fill = 1'b1;
    vid_req = 1'b0; vid_addr = '0; aud_req = 1'b0; aud_addr = '0;
    cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      for (int i = 0; i < 2**AW; i++) m_mem[k][i] = init_val(i);
    end
    repeat (2) @(posedge clk);
    fill = 1'b0;
    @(negedge clk);
    sample();
    @(negedge clk);

    // cpu read of 0x010 straight out of reset
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 1'b1; cpu_we[k] = 1'b0; cpu_addr[k] = 11'h010;
    end
    for (int c = 0; c < 8; c++) begin
      if (c == 5) cpu_req = '0;
      sample();
      check("t1_gnt", 0, cpu_gnt[0], c == 1);
      check("t1_done", 0, cpu_done[0], c >= 3 && c <= 5);
      if (c >= 4 && c <= 6) check("t1_rdata", 0, cpu_rdata[0], 8'h5A);
      @(negedge clk);
    end

    // video holds 8 cycles while the cpu waits
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 1'b1; cpu_we[k] = 1'b0; cpu_addr[k] = 11'h123;
    end
    for (int c = 0; c < 11; c++) begin
      vid_req  = (c < 8);
      vid_addr = AW'(c + 64);
      if (c > 0) for (int k = 0; k < 2; k++) cpu_drive(k, 0);
      sample();
      check("t2_vid", 0, vid_gnt[0], c < 8);
      check("t2_cpu", 0, cpu_gnt[0], c == 8);
      check("t2_vrv", 0, vid_rvalid[0], c >= 1 && c <= 8);
      @(negedge clk);
    end
    idle(5);

    // audio and cpu contend, audio first
    aud_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      aud_addr = AW'($urandom);
      for (int k = 0; k < 2; k++) cpu_drive(k, 100);
      sample();
      if (c == 0) check("t3_first", 0, {aud_gnt[0], cpu_gnt[0]}, 2'b10);
      @(negedge clk);
    end
    idle(5);

    // starvation guard: write 0xA3 to 0x7FF under continuous video
    vid_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 1'b1; cpu_we[k] = 1'b1; cpu_addr[k] = 11'h7FF; cpu_wdata[k] = 8'hA3;
    end
    for (int c = 0; c < 8; c++) begin
      vid_addr = AW'(c);
      if (c > 0) for (int k = 0; k < 2; k++) cpu_drive(k, 0);
      sample();
      check("t4_cpu", 1, cpu_gnt[1], c == 4);
      check("t4_vid", 1, vid_gnt[1], c != 4);
      if (c == 4) begin
        check("t4_we", 1, ram_we[1], 1);
        check("t4_addr", 1, ram_addr[1], 11'h7FF);
        check("t4_wdata", 1, ram_wdata[1], 8'hA3);
      end
      @(negedge clk);
    end
    idle(6);

    // reset right behind an audio read grant
    cpu_req = '0;
    aud_req = 1'b1;
    aud_addr = 11'h055;
    sample();
    check("t5_gnt", 0, aud_gnt[0], 1);
    #2 reset_n = 1'b0;
    for (int k = 0; k < 2; k++) model_clear(k);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      sample();
      check("t5_rv", 0, aud_rvalid[0], 0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("t5_first", 0, aud_gnt[0], c >= 1);
      check("t5_rv_rel", 0, aud_rvalid[0], c >= 2);
      @(negedge clk);
    end
    idle(3);

    // randomised traffic
    for (int c = 0; c < 10000; c++) begin
      vid_req  = ($urandom_range(0, 3) == 0);
      vid_addr = AW'($urandom);
      aud_req  = 1'($urandom_range(0, 1));
      aud_addr = AW'($urandom);
      for (int k = 0; k < 2; k++) cpu_drive(k, 40);
      sample();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
